pipe_fetch_unit: RTL and testbench
==================================

# pipe_fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It feeds the decode stage and consumes decode's redirect and stall outputs: `bpc`, `jpc`, `da`, `pcsource` and `wpcir`. It fetches over a request/acknowledge instruction-memory port that may take one or more cycles per word. It holds one fetched word in a skid entry while decode stalls, and applies branch/jump redirects with one-delay-slot semantics.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `pcsource`  in  2  from decode: 00 sequential, 01 branch (`bpc`), 10 register jump (`da`), 11 jump (`jpc`).
- `bpc`, `jpc`, `da`  in  32 each  redirect targets from decode.
- `wpcir`  in  1  decode may advance; 0 means stall.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  `imem_rdata` is valid this cycle; may be asserted in the same cycle as the request.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  next fetch address (PC register).
- `dpc4`  out  32  IF/ID: address of the decode instruction plus 4.
- `inst`  out  32  IF/ID: instruction in decode. 32'h0 (sll $0,$0,0) is a bubble.

## Operation
- FSM states:
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - HOLD: the skid entry is full and `imem_req`=0.
- Reset values:
  - PC register = `RESET_PC`; `inst` = 0; `dpc4` = 0; skid empty; no redirect pending.
  - FSM enters FETCH on the first edge after `resetn` rises.
- Ack in FETCH with `wpcir`=1:
  - IF/ID loads {`imem_rdata`, `pc`+4}.
  - `pc` advances to the pending target if one is set (and the pending target clears); otherwise `pc`+4.
- Ack in FETCH with `wpcir`=0:
  - The word goes into skid; `pc` advances by the same rule; FSM moves to HOLD.
- No ack in FETCH:
  - `wpcir`=1: IF/ID loads the bubble (`inst`=0, `dpc4` unchanged).
  - `wpcir`=0: IF/ID holds.
- HOLD:
  - `wpcir`=1: skid moves into IF/ID and FSM returns to FETCH.
  - `wpcir`=0: everything holds.
- Redirect is sampled only on an edge with `wpcir`=1 and `pcsource`≠00. Target is `bpc`, `da` or `jpc` as selected.
  - Case A, the delay-slot fetch is still outstanding in FETCH with no ack this cycle: the target is latched as pending. It replaces `pc`+4 on the next ack.
  - Case A with an ack the same cycle: that ack is the delay slot, so `pc` loads the target directly.
  - Case B, HOLD: the skid (the delay slot) moves to IF/ID and `pc` loads the target directly.
- Invariant: the fetch unit runs at most one instruction ahead of decode, outstanding or in skid. The delay slot is always the next instruction delivered.
- Arithmetic is 32-bit and wraps modulo 2^32. Bit[1:0] of targets pass through unchecked.
- Reset mid-request: abandon the request; `imem_req` drops asynchronously with reset.

## Timing
- With zero-wait memory (ack same cycle as req) and no stalls, one instruction is delivered per cycle. `inst` appears on the edge after `imem_addr` is driven.
- With N wait cycles, each instruction takes N+1 cycles and decode sees N bubbles.
- A redirect adds no extra bubbles beyond memory latency. The target fetch starts in the cycle after the delay slot is acknowledged (Case A) or after the stall releases (Case B).
- `imem_req` and `imem_addr` are registered-state outputs and never depend combinationally on `imem_ack`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `bubble_cnt` (32) and `hold_cnt` (32), both reset to 0 and wrapping.
  - `bubble_cnt` increments on every bubble inserted into IF/ID.
  - `hold_cnt` increments on every cycle spent in HOLD.
- Undefined: these ports and counters do not exist, and function is otherwise identical.

## Structure
- Shared package holds:
  - `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_JR`, `PCSRC_J` (2'b00–2'b11).
  - `INST_NOP` = 32'h0.
  - Fetch FSM state encoding (FETCH, HOLD).
- One sub-module, `fetch_skid`: a one-entry {inst, pc4} holding register with load/unload/full. The FSM, PC register, pending-redirect register and IF/ID live in the top.

## Test plan
- Reset, zero-wait memory, words 0x20010001, 0x20020002, ... → `imem_addr` 0,4,8 on consecutive cycles; `inst` follows one cycle later; `dpc4` = 4,8,12.
- Memory with 2 wait cycles → two `inst`=0 bubbles between instructions; `pc` steps by 4 only on ack.
- `wpcir`=0 for 3 cycles while the ack for addr 8 arrives → skid holds word, `imem_req`=0, `inst` frozen. Release → word 8 enters IF/ID with `dpc4`=12, and a request for 12 starts.
- Branch in decode (`pcsource`=01, `bpc`=0x40) while the delay slot at 0x14 is outstanding (1 wait cycle) → 0x14 delivered next, then `imem_addr`=0x40.
- `pcsource`=10, `da`=0x100, arriving while in HOLD (Case B) → skid word becomes `inst`; next `imem_addr`=0x100.
- Assert `resetn`=0 mid-request → `imem_req`=0, `inst`=0 and `pc`=`RESET_PC` immediately. With `FETCH_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/pipe_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pipe_fetch_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ifid_t;

  function automatic logic [31:0] redirect_target(input logic [1:0] sel,
                                                  input logic [31:0] bpc,
                                                  input logic [31:0] jpc,
                                                  input logic [31:0] da);
    case (sel)
      PCSRC_BR: return bpc;
      PCSRC_JR: return da;
      PCSRC_J:  return jpc;
      default:  return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_fetch_unit_skid.sv
// One-entry holding register for a fetched {inst, pc4} word while decode stalls.
module fetch_skid
  import pipe_fetch_unit_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  load,
  input  logic  unload,
  input  ifid_t load_entry,
  output ifid_t entry,
  output logic  full
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= load_entry;
    end else if (unload) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch + IF/ID register with one-delay-slot redirects.
// Optional FETCH_PERF_EN adds bubble_cnt / hold_cnt performance counters.
//
// state    | meaning
// IDLE     | out of reset, no request yet
// FETCH    | imem_req=1, imem_addr=pc
// HOLD     | skid full, decode stalled, imem_req=0
module pipe_fetch_unit
  import pipe_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
`endif
);

  logic [1:0]  state;
  logic [31:0] pc_reg;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next_seq;
  logic        in_fetch;
  logic        in_hold;
  logic        skid_load;
  logic        skid_unload;
  logic        skid_full;
  ifid_t       skid_entry;

  assign redirect    = wpcir && (pcsource != PCSRC_SEQ);
  assign target      = redirect_target(pcsource, bpc, jpc, da);
  assign pc_plus4    = pc_reg + 32'd4;
  assign pc_next_seq = pend_valid ? pend_target : pc_plus4;
  assign in_fetch    = (state == ST_FETCH);
  assign in_hold     = (state == ST_HOLD);
  assign skid_load   = in_fetch && imem_ack && !wpcir;
  assign skid_unload = in_hold && wpcir && skid_full;

  assign imem_req  = in_fetch;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;

  fetch_skid u_skid (
    .clock      (clock),
    .resetn     (resetn),
    .load       (skid_load),
    .unload     (skid_unload),
    .load_entry ('{inst: imem_rdata, pc4: pc_plus4}),
    .entry      (skid_entry),
    .full       (skid_full)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pc_reg      <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      inst        <= INST_NOP;
      dpc4        <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            // A redirect in the same cycle as an ack means this ack is the delay slot.
            pc_reg     <= redirect ? target : pc_next_seq;
            pend_valid <= 1'b0;
            if (wpcir) begin
              inst <= imem_rdata;
              dpc4 <= pc_plus4;
            end else begin
              state <= ST_HOLD;
            end
          end else begin
            if (redirect) begin
              pend_valid  <= 1'b1;
              pend_target <= target;
            end
            if (wpcir) inst <= INST_NOP;
          end
        end
        ST_HOLD: begin
          if (skid_unload) begin
            inst  <= skid_entry.inst;
            dpc4  <= skid_entry.pc4;
            state <= ST_FETCH;
            if (redirect) pc_reg <= target;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bubble_cnt <= 32'h0;
      hold_cnt   <= 32'h0;
    end else begin
      if (in_fetch && !imem_ack && wpcir) bubble_cnt <= bubble_cnt + 32'd1;
      if (in_hold) hold_cnt <= hold_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Self-checking bench for pipe_fetch_unit: vector table, delivery scoreboard, corner sequences.
module tb_pipe_fetch_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, da;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt, hold_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int nwait = 0;
  int wcnt  = 0;
  logic mon_en = 1'b0;

  always #5 clock = ~clock;

  pipe_fetch_unit dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .da         (da),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [15:0] k;
    k = a[17:2] + 16'd1;
    return 32'h2000_0000 | {k, 16'h0} | {16'h0, k};
  endfunction

  // Memory model: ack after nwait cycles of an outstanding request.
  assign imem_ack   = imem_req && (wcnt >= nwait);
  assign imem_rdata = word_at(imem_addr);

  always @(posedge clock or negedge resetn) begin
    if (!resetn) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic [31:0] a);
    sbq.push_back('{inst: word_at(a), pc4: a + 32'd4});
  endtask

  // Scoreboard: every new non-bubble word in IF/ID must match the next expected delivery.
  logic [31:0] prev_inst = 32'h0, prev_dpc4 = 32'h0;
  always @(posedge clock) begin
    exp_t e;
    #2;
    if (mon_en && resetn && inst != 32'h0 && (inst != prev_inst || dpc4 != prev_dpc4)) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got inst %h dpc4 %h expected none", inst, dpc4);
      end else begin
        e = sbq.pop_front();
        check("sb_inst", inst, e.inst);
        check("sb_dpc4", dpc4, e.pc4);
      end
    end
    prev_inst = inst;
    prev_dpc4 = dpc4;
  end

  task automatic do_reset(input int w);
    mon_en   = 1'b0;
    resetn   = 1'b0;
    wpcir    = 1'b1;
    pcsource = 2'b00;
    nwait    = w;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic end_test(input string name);
    mon_en = 1'b0;
    check(name, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_inst(input string name, input logic [31:0] a, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (inst !== word_at(a) && n < limit);
    if (inst !== word_at(a)) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got inst %h expected %h", name, inst, word_at(a));
    end
  endtask

  typedef struct {
    logic        rstv;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] dpc4;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; wpcir = 1'b1; pcsource = 2'b00;
    bpc = 32'h0; jpc = 32'h0; da = 32'h0;

    vecs[0] = '{1'b0, 1'b0, 32'h0,  32'h0,          32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0,  32'h0,          32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h4,  word_at(32'h0), 32'h4};
    vecs[3] = '{1'b1, 1'b1, 32'h8,  word_at(32'h4), 32'h8};
    vecs[4] = '{1'b1, 1'b1, 32'hc,  word_at(32'h8), 32'hc};
    vecs[5] = '{1'b1, 1'b1, 32'h10, word_at(32'hc), 32'h10};

    // zero-wait streaming from reset
    push(32'h0); push(32'h4); push(32'h8); push(32'hc);
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      resetn = vecs[i].rstv;
      @(negedge clock);
      check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_pc", i), pc, vecs[i].addr);
      check($sformatf("v%0d_inst", i), inst, vecs[i].inst);
      check($sformatf("v%0d_dpc4", i), dpc4, vecs[i].dpc4);
    end
    end_test("t1_drain");

    // two wait cycles: two bubbles per instruction
    do_reset(2);
    push(32'h0); push(32'h4);
    @(negedge clock);
    check("t2_req", {31'h0, imem_req}, 32'h1);
    repeat (3) @(negedge clock);
    check("t2_inst0", inst, word_at(32'h0));
    check("t2_pc0", pc, 32'h4);
    @(negedge clock);
    check("t2_bub1", inst, 32'h0);
    check("t2_bub1_dpc4", dpc4, 32'h4);
    check("t2_bub1_pc", pc, 32'h4);
    @(negedge clock);
    check("t2_bub2", inst, 32'h0);
    check("t2_bub2_pc", pc, 32'h4);
    @(negedge clock);
    check("t2_inst1", inst, word_at(32'h4));
    check("t2_pc1", pc, 32'h8);
`ifdef FETCH_PERF_EN
    check("t2_bubble_cnt", bubble_cnt, 32'd4);
    check("t2_hold_cnt", hold_cnt, 32'd0);
`endif
    end_test("t2_drain");

    // stall across the ack for address 8
    do_reset(0);
    push(32'h0); push(32'h4); push(32'h8);
    repeat (3) @(negedge clock);
    check("t3_pre_inst", inst, word_at(32'h4));
    check("t3_pre_addr", imem_addr, 32'h8);
    wpcir = 1'b0;
    @(negedge clock);
    check("t3_hold_req", {31'h0, imem_req}, 32'h0);
    check("t3_hold_inst", inst, word_at(32'h4));
    check("t3_hold_pc", pc, 32'hc);
    repeat (2) @(negedge clock);
    check("t3_hold3_req", {31'h0, imem_req}, 32'h0);
    check("t3_hold3_inst", inst, word_at(32'h4));
    check("t3_hold3_dpc4", dpc4, 32'h8);
    wpcir = 1'b1;
    @(negedge clock);
    check("t3_rel_inst", inst, word_at(32'h8));
    check("t3_rel_dpc4", dpc4, 32'hc);
    check("t3_rel_req", {31'h0, imem_req}, 32'h1);
    check("t3_rel_addr", imem_addr, 32'hc);
`ifdef FETCH_PERF_EN
    check("t3_hold_cnt", hold_cnt, 32'd3);
    check("t3_bubble_cnt", bubble_cnt, 32'd0);
`endif
    end_test("t3_drain");

    // Case A: branch while delay slot 0x14 is outstanding (1 wait cycle)
    do_reset(1);
    push(32'h0); push(32'h4); push(32'h8); push(32'hc);
    push(32'h10); push(32'h14); push(32'h40);
    wait_inst("t4_wait_br", 32'h10, 40);
    check("t4_ds_addr", imem_addr, 32'h14);
    pcsource = 2'b01; bpc = 32'h40;
    @(negedge clock);
    check("t4_bubble", inst, 32'h0);
    check("t4_ds_still", imem_addr, 32'h14);
    pcsource = 2'b00; bpc = 32'hdead_0000;
    @(negedge clock);
    check("t4_ds_inst", inst, word_at(32'h14));
    check("t4_tgt_addr", imem_addr, 32'h40);
    wait_inst("t4_wait_tgt", 32'h40, 10);
    check("t4_tgt_dpc4", dpc4, 32'h44);
    end_test("t4_drain");

    // Case B: register jump arriving while in HOLD
    do_reset(0);
    push(32'h0); push(32'h4); push(32'h8); push(32'h100);
    wait_inst("t5_wait", 32'h4, 10);
    wpcir = 1'b0;
    repeat (2) @(negedge clock);
    check("t5_hold_req", {31'h0, imem_req}, 32'h0);
    wpcir = 1'b1; pcsource = 2'b10; da = 32'h100;
    @(negedge clock);
    check("t5_skid_inst", inst, word_at(32'h8));
    check("t5_skid_dpc4", dpc4, 32'hc);
    check("t5_tgt_addr", imem_addr, 32'h100);
    check("t5_tgt_req", {31'h0, imem_req}, 32'h1);
    pcsource = 2'b00; da = 32'h0;
    @(negedge clock);
    check("t5_tgt_inst", inst, word_at(32'h100));
    check("t5_tgt_addr2", imem_addr, 32'h104);
    end_test("t5_drain");

    // Case A with ack in the same cycle as the jump
    do_reset(0);
    push(32'h0); push(32'h4); push(32'h8); push(32'h200);
    wait_inst("t6_wait", 32'h4, 10);
    pcsource = 2'b11; jpc = 32'h200;
    @(negedge clock);
    check("t6_ds_inst", inst, word_at(32'h8));
    check("t6_tgt_addr", imem_addr, 32'h200);
    pcsource = 2'b00; jpc = 32'h0;
    @(negedge clock);
    check("t6_tgt_inst", inst, word_at(32'h200));
    check("t6_tgt_dpc4", dpc4, 32'h204);
    end_test("t6_drain");

    // reset while a request is outstanding
    do_reset(3);
    push(32'h0);
    wait_inst("t7_wait", 32'h0, 20);
    check("t7_pre_req", {31'h0, imem_req}, 32'h1);
    check("t7_pre_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_EN
    check("t7_pre_bubble_cnt", bubble_cnt, 32'd3);
`endif
    end_test("t7_drain");
    resetn = 1'b0;
    #1;
    check("t7_rst_req", {31'h0, imem_req}, 32'h0);
    check("t7_rst_inst", inst, 32'h0);
    check("t7_rst_pc", pc, 32'h0);
    check("t7_rst_dpc4", dpc4, 32'h0);
`ifdef FETCH_PERF_EN
    check("t7_rst_bubble_cnt", bubble_cnt, 32'd0);
    check("t7_rst_hold_cnt", hold_cnt, 32'd0);
`endif
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
